mux_n_skid: RTL and testbench



---
 rtl/mux_n_skid.sv | 89 ++++++++
 tb/tb_mux_n_skid.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_skid.sv
// N-way registered select mux with valid/ready handshake and a two-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining MUX_N_SKID_SEL_ERR_EN.
module mux_n_skid #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    logic                 skid_valid;
    logic [WIDTH-1:0]     skid_data;
    logic [SEL_W-1:0]     skid_sel;
    logic [WIDTH-1:0]     sel_word;
    logic                 accept;
    logic                 out_load;

    // Selects that match no input fall back to input 0
    always_comb begin
        sel_word = in_data[0 +: WIDTH];
        for (int k = 1; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign out_load = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_sel   <= skid_sel;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_word;
                out_sel   <= sel;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // A full skid blocks accepts, so draining and refilling never coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
        end else if (out_load && skid_valid) begin
            skid_valid <= 1'b0;
        end else if (accept && out_valid && !out_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= sel_word;
            skid_sel   <= sel;
        end
    end

`ifdef MUX_N_SKID_SEL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && (int'(sel) >= N)) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_skid.sv
// Self-checking bench for mux_n_skid: directed vector table, random scoreboard run,
// out-of-range select on a 3-input instance, and mid-operation reset.
module tb_mux_n_skid;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;

`ifdef MUX_N_SKID_SEL_ERR_EN
    localparam logic SEL_ERR_EXP = 1'b1;
`else
    localparam logic SEL_ERR_EXP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     in_words [N];
    logic [N*WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]     sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;

    logic [3*WIDTH-1:0]   in_data3;
    logic [SEL_W-1:0]     sel3;
    logic                 in_valid3;
    logic                 in_ready3;
    logic [WIDTH-1:0]     out_data3;
    logic [SEL_W-1:0]     out_sel3;
    logic                 out_valid3;
    logic                 out_ready3;
    logic                 sel_err3;

    int checks = 0;
    int errors = 0;

    assign in_data  = {in_words[3], in_words[2], in_words[1], in_words[0]};
    assign in_data3 = {32'h33, 32'h22, 32'h11};

    always #5 clk = ~clk;

    mux_n_skid #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_n_skid #(.WIDTH(WIDTH), .N(3), .SEL_W(SEL_W)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
    );

    typedef struct {
        logic             iv;
        logic [1:0]       s;
        logic             ordy;
        logic             eov;
        logic [31:0]      edata;
        logic [1:0]       esel;
        logic             eir;
    } vec_t;

    typedef struct packed {
        logic [1:0]  s;
        logic [31:0] d;
    } word_t;

    vec_t  vecs [14];
    word_t sb [$];

    task automatic applyStimulus(input logic iv, input logic [1:0] s, input logic ordy);
        in_valid  = iv;
        sel       = s;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle vectors: inputs applied, then outputs checked after the next edge
        vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 32'h11, 2'd0, 1'b1};
        vecs[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h22, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h33, 2'd2, 1'b1};
        vecs[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h44, 2'd3, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'h22, 2'd1, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 1'b1, 32'h22, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h33, 2'd2, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 1'b1, 32'h11, 2'd0, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h11, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h44, 2'd3, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};

        in_words[0] = 32'h11;
        in_words[1] = 32'h22;
        in_words[2] = 32'h33;
        in_words[3] = 32'h44;
        applyStimulus(1'b0, 2'd0, 1'b0);
        in_valid3  = 1'b0;
        sel3       = 2'd0;
        out_ready3 = 1'b0;
        rst = 1'b1;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_sel", out_sel, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset sel_err", sel_err, 0);
        checkOutput("reset sel_err3", sel_err3, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle out_valid", out_valid, 0);
        checkOutput("idle in_ready", in_ready, 1);

        // Streaming and backpressure vectors
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].s, vecs[i].ordy);
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), out_valid, vecs[i].eov);
            checkOutput($sformatf("vec%0d in_ready", i), in_ready, vecs[i].eir);
            if (vecs[i].eov) begin
                checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].edata);
                checkOutput($sformatf("vec%0d out_sel", i), out_sel, vecs[i].esel);
            end
        end

        // Out-of-range select on the 3-input instance
        in_valid3 = 1'b1; sel3 = 2'd2; out_ready3 = 1'b1;
        tick();
        checkOutput("oor in-range data", out_data3, 32'h33);
        checkOutput("oor in-range sel_err", sel_err3, 0);
        sel3 = 2'd3;
        tick();
        checkOutput("oor valid", out_valid3, 1);
        checkOutput("oor data", out_data3, 32'h11);
        checkOutput("oor out_sel", out_sel3, 3);
        checkOutput("oor sel_err", sel_err3, SEL_ERR_EXP);
        in_valid3 = 1'b0;
        tick();
        checkOutput("oor idle valid", out_valid3, 0);
        checkOutput("oor sticky idle", sel_err3, SEL_ERR_EXP);
        in_valid3 = 1'b1; sel3 = 2'd1;
        tick();
        checkOutput("oor next data", out_data3, 32'h22);
        checkOutput("oor sticky next", sel_err3, SEL_ERR_EXP);
        in_valid3 = 1'b0;

        // Random traffic against a FIFO scoreboard
        begin
            logic            prev_stall;
            logic [31:0]     prev_data;
            logic [1:0]      prev_sel;
            word_t           w;
            prev_stall = 1'b0;
            prev_data  = '0;
            prev_sel   = '0;
            sb.delete();
            for (int c = 0; c < 10000; c++) begin
                for (int k = 0; k < N; k++) in_words[k] = $urandom;
                applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)));
                if (prev_stall) begin
                    checkOutput("rand stall data", out_data, prev_data);
                    checkOutput("rand stall sel", out_sel, prev_sel);
                    checkOutput("rand stall valid", out_valid, 1);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("rand unexpected output", 1, 0);
                    end else begin
                        w = sb.pop_front();
                        checkOutput("rand order data", out_data, w.d);
                        checkOutput("rand order sel", out_sel, w.s);
                    end
                end
                if (in_valid && in_ready) begin
                    w.s = sel;
                    w.d = in_words[sel];
                    sb.push_back(w);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_sel   = out_sel;
                tick();
                checkOutput("rand outstanding", (sb.size() <= 2), 1);
                checkOutput("rand out_valid", out_valid, (sb.size() != 0));
                checkOutput("rand in_ready", in_ready, (sb.size() < 2));
            end
        end

        // Drain, fill both entries, then reset between edges
        in_words[0] = 32'h11;
        in_words[1] = 32'h22;
        in_words[2] = 32'h33;
        in_words[3] = 32'h44;
        applyStimulus(1'b0, 2'd0, 1'b1);
        repeat (3) tick();
        checkOutput("drain out_valid", out_valid, 0);
        applyStimulus(1'b1, 2'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd1, 1'b0);
        tick();
        checkOutput("full out_valid", out_valid, 1);
        checkOutput("full out_data", out_data, 32'h11);
        checkOutput("full in_ready", in_ready, 0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", out_valid, 0);
        checkOutput("midrst out_data", out_data, 0);
        checkOutput("midrst in_ready", in_ready, 1);
        checkOutput("midrst sel_err3", sel_err3, 0);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 2'd2, 1'b1);
        tick();
        checkOutput("postrst out_valid", out_valid, 1);
        checkOutput("postrst out_data", out_data, 32'h33);
        checkOutput("postrst out_sel", out_sel, 2);
        applyStimulus(1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("postrst empty", out_valid, 0);
        checkOutput("postrst in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
